// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: three producers each feed a 2-entry FIFO; one result per
// cycle is granted round-robin and broadcast on a registered CDB.
module cdb_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                ROB_roll_back_flag,
  input  logic                ALU_valid,
  input  logic [ROB_ID_W-1:0] ALU_ROB_id,
  input  logic [DATA_W-1:0]   ALU_value,
  output logic                ALU_ready,
  input  logic                LSB_valid,
  input  logic [ROB_ID_W-1:0] LSB_ROB_id,
  input  logic [DATA_W-1:0]   LSB_value,
  output logic                LSB_ready,
  input  logic                BR_valid,
  input  logic [ROB_ID_W-1:0] BR_ROB_id,
  input  logic [DATA_W-1:0]   BR_value,
  output logic                BR_ready,
  output logic                CDB_valid,
  output logic [ROB_ID_W-1:0] CDB_ROB_id,
  output logic [DATA_W-1:0]   CDB_value,
  output logic [1:0]          CDB_src
);

  localparam int unsigned NSRC  = 3;
  localparam int unsigned ENT_W = ROB_ID_W + DATA_W;

  logic [ENT_W-1:0] r_mem  [NSRC][2];
  logic [1:0]       r_cnt  [NSRC];
  logic             r_head [NSRC];
  logic             r_tail [NSRC];
  logic [1:0]       r_rr;

  logic [NSRC-1:0]  w_in_valid;
  logic [ENT_W-1:0] w_in_data [NSRC];
  logic [NSRC-1:0]  w_push;
  logic [NSRC-1:0]  w_pop;
  logic [NSRC-1:0]  w_nonempty;
  logic             w_clear;
  logic             w_grant;
  logic [1:0]       w_win;
  logic [ENT_W-1:0] w_win_data;

  // (a + b) mod 3 for source indices in 0..2
  function automatic logic [1:0] wrap3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  assign w_clear      = rst | ROB_roll_back_flag;
  assign w_in_valid   = {BR_valid, LSB_valid, ALU_valid};
  assign w_in_data[0] = {ALU_ROB_id, ALU_value};
  assign w_in_data[1] = {LSB_ROB_id, LSB_value};
  assign w_in_data[2] = {BR_ROB_id, BR_value};

  assign ALU_ready = (r_cnt[0] != 2'd2);
  assign LSB_ready = (r_cnt[1] != 2'd2);
  assign BR_ready  = (r_cnt[2] != 2'd2);

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign w_push[g]     = rdy && !w_clear && w_in_valid[g] && (r_cnt[g] != 2'd2);
    assign w_nonempty[g] = (r_cnt[g] != 2'd0);
    assign w_pop[g]      = w_grant && (w_win == 2'(g));
  end

  // Round-robin search starting at r_rr; first non-empty source wins
  always_comb begin
    logic [1:0] v_idx;
    w_grant = 1'b0;
    w_win   = 2'd0;
    v_idx   = 2'd0;
    for (int k = 0; k < NSRC; k++) begin
      v_idx = wrap3(r_rr, 2'(k));
      if (rdy && !w_clear && !w_grant && w_nonempty[v_idx]) begin
        w_grant = 1'b1;
        w_win   = v_idx;
      end
    end
  end

  assign w_win_data = r_mem[w_win][r_head[w_win]];

  // Payload storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++) begin
      if (w_push[s]) r_mem[s][r_tail[s]] <= w_in_data[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSRC; s++) begin
        r_cnt[s]  <= 2'd0;
        r_head[s] <= 1'b0;
        r_tail[s] <= 1'b0;
      end
      r_rr       <= 2'd0;
      CDB_valid  <= 1'b0;
      CDB_ROB_id <= '0;
      CDB_value  <= '0;
      CDB_src    <= 2'd0;
    end else if (ROB_roll_back_flag) begin
      for (int s = 0; s < NSRC; s++) begin
        r_cnt[s]  <= 2'd0;
        r_head[s] <= 1'b0;
        r_tail[s] <= 1'b0;
      end
      r_rr      <= 2'd0;
      CDB_valid <= 1'b0;
    end else if (rdy) begin
      for (int s = 0; s < NSRC; s++) begin
        if (w_push[s]) r_tail[s] <= ~r_tail[s];
        if (w_pop[s])  r_head[s] <= ~r_head[s];
        r_cnt[s] <= r_cnt[s] + 2'(w_push[s]) - 2'(w_pop[s]);
      end
      CDB_valid <= w_grant;
      if (w_grant) begin
        r_rr       <= wrap3(w_win, 2'd1);
        CDB_ROB_id <= w_win_data[ENT_W-1 -: ROB_ID_W];
        CDB_value  <= w_win_data[DATA_W-1:0];
        CDB_src    <= w_win;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: reset, single result, contention,
// back-pressure, roll-back and stall scenarios with hand-computed expectations.
module tb_cdb_arbiter;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ROB_ID_W = 4;

  logic                clk = 1'b0;
  logic                rst, rdy, ROB_roll_back_flag;
  logic                ALU_valid, LSB_valid, BR_valid;
  logic [ROB_ID_W-1:0] ALU_ROB_id, LSB_ROB_id, BR_ROB_id;
  logic [DATA_W-1:0]   ALU_value, LSB_value, BR_value;
  logic                ALU_ready, LSB_ready, BR_ready;
  logic                CDB_valid;
  logic [ROB_ID_W-1:0] CDB_ROB_id;
  logic [DATA_W-1:0]   CDB_value;
  logic [1:0]          CDB_src;

  int n_chk  = 0;
  int n_pass = 0;

  cdb_arbiter #(.DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ROB_roll_back_flag(ROB_roll_back_flag),
    .ALU_valid(ALU_valid), .ALU_ROB_id(ALU_ROB_id), .ALU_value(ALU_value), .ALU_ready(ALU_ready),
    .LSB_valid(LSB_valid), .LSB_ROB_id(LSB_ROB_id), .LSB_value(LSB_value), .LSB_ready(LSB_ready),
    .BR_valid(BR_valid), .BR_ROB_id(BR_ROB_id), .BR_value(BR_value), .BR_ready(BR_ready),
    .CDB_valid(CDB_valid), .CDB_ROB_id(CDB_ROB_id), .CDB_value(CDB_value), .CDB_src(CDB_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and settle past it before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ALU_valid = 0; LSB_valid = 0; BR_valid = 0;
    ALU_ROB_id = 0; LSB_ROB_id = 0; BR_ROB_id = 0;
    ALU_value = 0; LSB_value = 0; BR_value = 0;
    ROB_roll_back_flag = 0;
  endtask

  task automatic do_reset();
    rst = 1; rdy = 1; idle_inputs();
    tick(); tick();
    rst = 0;
  endtask

  task automatic chk_bcast(input string tag, input logic [3:0] id, input logic [31:0] val,
                           input logic [1:0] src);
    chk({tag, ".valid"}, 64'(CDB_valid), 64'd1);
    chk({tag, ".id"}, 64'(CDB_ROB_id), 64'(id));
    chk({tag, ".value"}, 64'(CDB_value), 64'(val));
    chk({tag, ".src"}, 64'(CDB_src), 64'(src));
  endtask

  initial begin
    logic [3:0] tags [3];
    logic [3:0] exp_tag [3];
    logic [2:0] pre_rdy;
    logic [1:0] exp_src;
    int accepted, seen;
    bit saw_alu_full;

    // Reset
    do_reset();
    chk("rst.valid", 64'(CDB_valid), 64'd0);
    chk("rst.id", 64'(CDB_ROB_id), 64'd0);
    chk("rst.value", 64'(CDB_value), 64'd0);
    chk("rst.src", 64'(CDB_src), 64'd0);
    chk("rst.ready", 64'({ALU_ready, LSB_ready, BR_ready}), 64'b111);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst.quiet", 64'(CDB_valid), 64'd0);
    end

    // Single result: push at edge k, broadcast after k+1, gone after k+2
    ALU_valid = 1; ALU_ROB_id = 5; ALU_value = 32'hDEADBEEF;
    tick();
    idle_inputs();
    chk("single.k", 64'(CDB_valid), 64'd0);
    tick();
    chk_bcast("single", 4'd5, 32'hDEADBEEF, 2'd0);
    tick();
    chk("single.end", 64'(CDB_valid), 64'd0);

    // Three-way contention from reset
    do_reset();
    ALU_valid = 1; ALU_ROB_id = 1; ALU_value = 32'd100;
    LSB_valid = 1; LSB_ROB_id = 2; LSB_value = 32'd200;
    BR_valid  = 1; BR_ROB_id  = 3; BR_value  = 32'd300;
    tick();
    idle_inputs();
    tick(); chk_bcast("c3.a", 4'd1, 32'd100, 2'd0);
    tick(); chk_bcast("c3.b", 4'd2, 32'd200, 2'd1);
    tick(); chk_bcast("c3.c", 4'd3, 32'd300, 2'd2);
    tick(); chk("c3.idle", 64'(CDB_valid), 64'd0);
    // rr is back at 0; ALU empty so LSB wins first
    LSB_valid = 1; LSB_ROB_id = 4; LSB_value = 32'd400;
    BR_valid  = 1; BR_ROB_id  = 6; BR_value  = 32'd600;
    tick();
    idle_inputs();
    tick(); chk_bcast("c2.a", 4'd4, 32'd400, 2'd1);
    tick(); chk_bcast("c2.b", 4'd6, 32'd600, 2'd2);
    tick(); chk("c2.idle", 64'(CDB_valid), 64'd0);

    // Back-pressure: all sources push whenever ready, tags count up per source
    do_reset();
    for (int s = 0; s < 3; s++) begin tags[s] = 0; exp_tag[s] = 0; end
    exp_src = 0; accepted = 0; seen = 0; saw_alu_full = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      ALU_valid = 1; ALU_ROB_id = tags[0]; ALU_value = 32'h000 + 32'(tags[0]);
      LSB_valid = 1; LSB_ROB_id = tags[1]; LSB_value = 32'h100 + 32'(tags[1]);
      BR_valid  = 1; BR_ROB_id  = tags[2]; BR_value  = 32'h200 + 32'(tags[2]);
      pre_rdy = {BR_ready, LSB_ready, ALU_ready};
      tick();
      for (int s = 0; s < 3; s++) if (pre_rdy[s]) begin tags[s]++; accepted++; end
      if (!ALU_ready) saw_alu_full = 1;
      if (cyc >= 1) chk("bp.valid", 64'(CDB_valid), 64'd1);
      if (CDB_valid) begin
        chk("bp.src", 64'(CDB_src), 64'(exp_src));
        chk("bp.id", 64'(CDB_ROB_id), 64'(exp_tag[exp_src]));
        chk("bp.value", 64'(CDB_value), 64'(32'(exp_src) * 32'h100 + 32'(exp_tag[exp_src])));
        exp_tag[exp_src]++;
        exp_src = (exp_src == 2'd2) ? 2'd0 : exp_src + 2'd1;
        seen++;
      end
    end
    idle_inputs();
    chk("bp.alu_full", 64'(saw_alu_full), 64'd1);
    // Drain: only per-source order matters now
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (CDB_valid) begin
        chk("drain.id", 64'(CDB_ROB_id), 64'(exp_tag[CDB_src]));
        exp_tag[CDB_src]++;
        seen++;
      end
    end
    chk("bp.count", 64'(seen), 64'(accepted));

    // Roll-back mid-stream with a same-cycle push that must be dropped
    for (int cyc = 0; cyc < 3; cyc++) begin
      ALU_valid = 1; ALU_ROB_id = 4'(12 + cyc); ALU_value = 32'd7;
      LSB_valid = 1; LSB_ROB_id = 4'(12 + cyc); LSB_value = 32'd7;
      BR_valid  = 1; BR_ROB_id  = 4'(12 + cyc); BR_value  = 32'd7;
      tick();
    end
    idle_inputs();
    ROB_roll_back_flag = 1; ALU_valid = 1; ALU_ROB_id = 7; ALU_value = 32'h77;
    tick();
    idle_inputs();
    chk("rb.valid", 64'(CDB_valid), 64'd0);
    chk("rb.ready", 64'({ALU_ready, LSB_ready, BR_ready}), 64'b111);
    ALU_valid = 1; ALU_ROB_id = 9; ALU_value = 32'h99;
    tick();
    idle_inputs();
    chk("rb.dropped", 64'(CDB_valid), 64'd0);
    tick(); chk_bcast("rb.after", 4'd9, 32'h99, 2'd0);
    tick(); chk("rb.idle", 64'(CDB_valid), 64'd0);

    // Stall: rr=1 so LSB goes first; rdy low freezes outputs and queue
    ALU_valid = 1; ALU_ROB_id = 10; ALU_value = 32'hA0;
    LSB_valid = 1; LSB_ROB_id = 11; LSB_value = 32'hB0;
    tick();
    idle_inputs();
    tick(); chk_bcast("st.first", 4'd11, 32'hB0, 2'd1);
    rdy = 0; BR_valid = 1; BR_ROB_id = 12; BR_value = 32'hC0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_bcast("st.hold", 4'd11, 32'hB0, 2'd1);
    end
    rdy = 1; idle_inputs();
    tick(); chk_bcast("st.resume", 4'd10, 32'hA0, 2'd0);
    tick(); chk("st.idle", 64'(CDB_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
